// File: rtl/systolic_mm_array_pkg.sv
// Shared types and width helpers for the systolic matrix-multiply array.
// Imported by the top level and by the processing element.
package systolic_mm_array_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDrain,
        StOut
    } state_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

    // Width of the k_len port: wide enough to hold KMAX itself.
    function automatic int unsigned k_width(input int unsigned kmax);
        return clog2_f(kmax) + 1;
    endfunction

    // Full product width plus headroom for KMAX accumulations.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned kmax);
        return 2 * dw + clog2_f(kmax);
    endfunction

endpackage

// File: rtl/mac_pe.sv
// Systolic processing element: registers a (rightwards) and b (downwards) and
// accumulates the product of the registered operands.
module mac_pe #(
    parameter int unsigned DW   = 8,
    parameter int unsigned ACCW = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            signed_mode,
    input  logic [DW-1:0]   a_in,
    input  logic [DW-1:0]   b_in,
    output logic [DW-1:0]   a_out,
    output logic [DW-1:0]   b_out,
    output logic [ACCW-1:0] acc
);

    localparam int unsigned XW = ACCW - 2 * DW;

    logic [DW-1:0]   a_q, b_q;
    logic [ACCW-1:0] acc_q;
    logic [2*DW-1:0] a_x, b_x, prod;
    logic [ACCW-1:0] prod_ext;

    // The low 2*DW bits of a product are the same for signed and unsigned
    // operands once they are extended the right way.
    assign a_x      = {{DW{signed_mode & a_q[DW-1]}}, a_q};
    assign b_x      = {{DW{signed_mode & b_q[DW-1]}}, b_q};
    assign prod     = a_x * b_x;
    assign prod_ext = {{XW{signed_mode & prod[2*DW-1]}}, prod};

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q <= a_in;
            b_q <= b_in;
            if (clear) begin
                acc_q <= '0;
            end else begin
                acc_q <= acc_q + prod_ext;
            end
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/systolic_mm_array.sv
// N x N output-stationary systolic array computing C = A * B over K streamed
// beats, then returning C one row per handshake.
module systolic_mm_array
    import systolic_mm_array_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned KMAX = 16,
    parameter int unsigned ACCW = acc_width(DW, KMAX)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [k_width(KMAX)-1:0]  k_len,
    input  logic                      signed_mode,
    input  logic                      acc_mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N*DW-1:0]           a_col,
    input  logic [N*DW-1:0]           b_row,
    output logic [N*ACCW-1:0]         c_row,
    output logic                      c_valid,
    output logic                      c_last,
    input  logic                      c_ready,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned KW  = k_width(KMAX);
    localparam int unsigned RW  = clog2_f(N);
    localparam int unsigned DCW = clog2_f(2 * N - 1);

    localparam logic [KW-1:0]  KMaxVal   = KW'(KMAX);
    localparam logic [RW-1:0]  RowLast   = RW'(N - 1);
    localparam logic [DCW-1:0] DrainLast = DCW'(2 * N - 2);

    state_e         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [KW-1:0]  beat_q, beat_d;
    logic [DCW-1:0] drain_q, drain_d;
    logic [RW-1:0]  row_q, row_d;
    logic           signed_q, signed_d;
    logic           done_q, done_d;
    logic           clear;
    logic           accept;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        beat_d   = beat_q;
        drain_d  = drain_q;
        row_d    = row_q;
        signed_d = signed_q;
        done_d   = 1'b0;
        clear    = 1'b0;
        in_ready = 1'b0;
        c_valid  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StLoad;
                    k_d      = (k_len > KMaxVal) ? KMaxVal : k_len;
                    signed_d = signed_mode;
                    beat_d   = '0;
                    clear    = ~acc_mode;
                end
            end
            StLoad: begin
                if (k_q == '0) begin
                    state_d = StDrain;
                    drain_d = '0;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        beat_d = beat_q + KW'(1);
                        if (beat_q == k_q - KW'(1)) begin
                            state_d = StDrain;
                            drain_d = '0;
                        end
                    end
                end
            end
            StDrain: begin
                // The last product reaches PE(N-1,N-1) on the edge that leaves DRAIN.
                if (drain_q == DrainLast) begin
                    state_d = StOut;
                    row_d   = '0;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            StOut: begin
                c_valid = 1'b1;
                if (c_ready) begin
                    if (row_q == RowLast) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            k_q      <= '0;
            beat_q   <= '0;
            drain_q  <= '0;
            row_q    <= '0;
            signed_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            beat_q   <= beat_d;
            drain_q  <= drain_d;
            row_q    <= row_d;
            signed_q <= signed_d;
            done_q   <= done_d;
        end
    end

    assign accept = in_valid & in_ready;
    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign c_last = c_valid & (row_q == RowLast);

    // ------------------------------------------------------------------
    // Input skew: lane i enters the array i cycles late; bubbles inject zero
    // ------------------------------------------------------------------
    logic [DW-1:0] a_edge [N];
    logic [DW-1:0] b_edge [N];

    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [DW-1:0] a_inj, b_inj;

        assign a_inj = accept ? a_col[i*DW +: DW] : '0;
        assign b_inj = accept ? b_row[i*DW +: DW] : '0;

        if (i == 0) begin : g_direct
            assign a_edge[i] = a_inj;
            assign b_edge[i] = b_inj;
        end else begin : g_delay
            logic [DW-1:0] a_sr_q [i];
            logic [DW-1:0] b_sr_q [i];

            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int s = 0; s < i; s++) begin
                        a_sr_q[s] <= '0;
                        b_sr_q[s] <= '0;
                    end
                end else begin
                    a_sr_q[0] <= a_inj;
                    b_sr_q[0] <= b_inj;
                    for (int s = 1; s < i; s++) begin
                        a_sr_q[s] <= a_sr_q[s-1];
                        b_sr_q[s] <= b_sr_q[s-1];
                    end
                end
            end

            assign a_edge[i] = a_sr_q[i-1];
            assign b_edge[i] = b_sr_q[i-1];
        end
    end

    // ------------------------------------------------------------------
    // PE grid
    // ------------------------------------------------------------------
    logic [DW-1:0]   a_pipe [N][N];
    logic [DW-1:0]   b_pipe [N][N];
    logic [ACCW-1:0] acc_w  [N][N];

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DW-1:0] a_in, b_in;

            if (j == 0) begin : g_a_edge
                assign a_in = a_edge[i];
            end else begin : g_a_chain
                assign a_in = a_pipe[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_in = b_edge[j];
            end else begin : g_b_chain
                assign b_in = b_pipe[i-1][j];
            end

            mac_pe #(
                .DW   (DW),
                .ACCW (ACCW)
            ) u_pe (
                .clk         (clk),
                .rst         (rst),
                .clear       (clear),
                .signed_mode (signed_q),
                .a_in        (a_in),
                .b_in        (b_in),
                .a_out       (a_pipe[i][j]),
                .b_out       (b_pipe[i][j]),
                .acc         (acc_w[i][j])
            );
        end
    end

    // Operands leaving the far edges of the grid have no consumer.
    logic unused_pipe;
    always_comb begin
        unused_pipe = 1'b0;
        for (int i = 0; i < N; i++) begin
            unused_pipe = unused_pipe ^ (^a_pipe[i][N-1]) ^ (^b_pipe[N-1][i]);
        end
    end

    always_comb begin
        c_row = '0;
        for (int j = 0; j < N; j++) begin
            c_row[j*ACCW +: ACCW] = acc_w[row_q][j];
        end
    end

endmodule
